// File: rtl/riscv_rf_pkg.sv
// Shared register-file definitions: clear-engine state, default sizes and
// the ABI register-name helper used when printing register indices.
package riscv_rf_pkg;

  typedef enum logic {RF_INIT = 1'b0, RF_RUN = 1'b1} rf_state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // ABI mnemonic for an integer register index, packed as up to 5 ASCII chars.
  function automatic logic [39:0] abi_name(input logic [4:0] idx);
    case (idx)
      5'd0:  return "zero"; 5'd1:  return "ra";  5'd2:  return "sp";  5'd3:  return "gp";
      5'd4:  return "tp";   5'd5:  return "t0";  5'd6:  return "t1";  5'd7:  return "t2";
      5'd8:  return "s0";   5'd9:  return "s1";  5'd10: return "a0";  5'd11: return "a1";
      5'd12: return "a2";   5'd13: return "a3";  5'd14: return "a4";  5'd15: return "a5";
      5'd16: return "a6";   5'd17: return "a7";  5'd18: return "s2";  5'd19: return "s3";
      5'd20: return "s4";   5'd21: return "s5";  5'd22: return "s6";  5'd23: return "s7";
      5'd24: return "s8";   5'd25: return "s9";  5'd26: return "s10"; 5'd27: return "s11";
      5'd28: return "t3";   5'd29: return "t4";  5'd30: return "t5";  default: return "t6";
    endcase
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register (x0 tied to 0),
// set on issue, cleared on writeback, wiped by flush. Produces per-port busy.
module rf_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              wr_en,     // raw write strobe, used to mask bypassed reads
  input  logic              clr_en,    // write actually accepted; clears the pending bit
  input  logic [AW-1:0]     wr_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] pending_q, pending_d;

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < NREGS;
  endfunction

  // Next pending vector: clear first so a same-cycle set (newer producer) wins;
  // flush overrides everything. Bit 0 is never set.
  always_comb begin
    pending_d = pending_q;
    if (run) begin
      if (flush) begin
        pending_d = '0;
      end else begin
        if (clr_en && in_range(wr_addr)) pending_d[wr_addr] = 1'b0;
        if (iss_en && in_range(iss_addr)) pending_d[iss_addr] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  // Pending register; cleared asynchronously with the rest of the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // A port is busy if its register is pending and not being written this cycle.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (run && in_range(rd_addr[i*AW +: AW])) begin
        rd_busy[i] = pending_q[rd_addr[i*AW +: AW]] &
                     ~(wr_en && (wr_addr == rd_addr[i*AW +: AW]));
      end
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with hardwired x0, write-through bypass,
// pending-write scoreboard and a post-reset clear engine (storage is unreset).
// Optional macro RF_XGUARD_EN: drop writes carrying X/Z data and report them.
module regfile_mp_sb
  import riscv_rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic                init_busy,
  output rf_state_e           dbg_state
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic            run;
  logic            wr_xbad;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  function automatic logic reg_valid(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREGS);
  endfunction

  assign run       = (state_q == RF_RUN);
  assign init_busy = ~run;
  assign dbg_state = state_q;

`ifdef RF_XGUARD_EN
  assign wr_xbad = ((^wr_data) === 1'bx);

  // Report writes whose data is not fully known; they are not committed.
  always @(posedge clk) begin
    if (run && wr_en && wr_xbad)
      $error("regfile_mp_sb: X write dropped at %0t addr=%0d data=%h", $time, wr_addr, wr_data);
  end
`else
  assign wr_xbad = 1'b0;
`endif

  // Clear engine: walk every register once after reset, then stay in RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == RF_INIT) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST) begin
        state_d   = RF_RUN;
        clr_cnt_d = '0;
      end
    end
  end

  // Clear-engine state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RF_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Single array write port shared by the clear engine and writeback.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
    end else if (wr_en && reg_valid(wr_addr) && !wr_xbad) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Combinational read ports with x0/out-of-range zeroing and write bypass.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (run && reg_valid(rd_addr[i*AW +: AW])) begin
        if (wr_en && (wr_addr == rd_addr[i*AW +: AW]))
          rd_data[i*XLEN +: XLEN] = wr_data;
        else
          rd_data[i*XLEN +: XLEN] = mem_q[rd_addr[i*AW +: AW]];
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (reset),
    .run      (run),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .clr_en   (wr_en & ~wr_xbad),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule
